// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Writer side of the CPU instruction memory. Receives a program image as a
// byte stream, writes it word by word into the 16-bit instruction memory, and
// holds the CPU in reset until the whole image has been written.
//
// Image format (after the SYNC_BYTE marker):
//   LEN_HI, LEN_LO            word count, big-endian
//   DATA_HI, DATA_LO  x len   word k is written to address k
//   CHK                       only with LOADER_CHECKSUM_EN defined
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   Defined   : one trailing checksum byte is accepted after the last word (or
//               straight after LEN_LO when len == 0). The 8-bit sum of LEN_HI,
//               LEN_LO, all data bytes and the checksum must be 8'h00, or the
//               image is rejected (words already written stay in memory).
//   Undefined : no checksum byte, no running sum.
//
// Parameters:
//   ADDR_W     instruction memory address width (depth 2**ADDR_W words)
//   SYNC_BYTE  start-of-image marker
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           synchronous active-high reset
//   in_data       incoming image byte
//   in_valid      in_data is valid
//   in_ready      loader can take a byte this cycle
//   mem_we        memory write enable, one-cycle pulse per word
//   mem_addr      word write address
//   mem_wdata     word write data
//   cpu_rst       holds the CPU control FSM in reset while high
//   done          image loaded successfully (sticky until rst)
//   error         image rejected (sticky until rst)
//   words_loaded  number of words written so far
//
// Handshake: a byte transfers at a posedge where in_valid & in_ready are both
// high. in_valid may drop for any number of cycles between bytes; in_ready is
// low while rst is high, so a byte offered during reset is never taken.
//
// The FSM state is held in the named register `state` for observation.
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHK
`endif
  } state_t;

  // Where the FSM goes once the last word has been written.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CHK;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  // Memory depth, kept wide enough that 2**16 is representable.
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  state_t      state;
  logic [15:0] len;
  logic [7:0]  hi_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  logic        accept;
  logic [15:0] next_len;
  logic [15:0] next_count;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        S_CHK: in_ready = 1'b1;
`endif
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept     = in_valid & in_ready;
  // Full length as it will be once the LEN_LO byte is latched.
  assign next_len   = {len[15:8], in_data};
  assign next_count = words_loaded + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_SYNC;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      hi_byte      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_SYNC: begin
          // Anything other than the marker is dropped while hunting.
          if (accept && in_data == SYNC_BYTE) state <= S_LEN_HI;
        end
        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_data;
`ifdef LOADER_CHECKSUM_EN
            sum       <= in_data;
`endif
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= in_data;
`ifdef LOADER_CHECKSUM_EN
            sum      <= sum + in_data;
`endif
            if (next_len == 16'd0)          state <= END_STATE;
            else if (33'(next_len) > DEPTH) state <= S_ERROR;
            else                            state <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            hi_byte <= in_data;
`ifdef LOADER_CHECKSUM_EN
            sum     <= sum + in_data;
`endif
            state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            mem_wdata    <= {hi_byte, in_data};
            mem_addr     <= ADDR_W'(words_loaded);
            mem_we       <= 1'b1;
            words_loaded <= next_count;
`ifdef LOADER_CHECKSUM_EN
            sum          <= sum + in_data;
`endif
            // The count stops exactly at len, so it can never wrap.
            state <= (next_count == len) ? END_STATE : S_DATA_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) state <= (8'(sum + in_data) == 8'h00) ? S_DONE : S_ERROR;
        end
`endif
        S_DONE: begin
          // One cycle after entry: the final write has been captured by now.
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end
        S_ERROR: begin
          error   <= 1'b1;
          cpu_rst <= 1'b1;
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule
